// File: rtl/cpu_regfile.sv
// Architectural register storage: independent GP (r0 = 0) and FP files,
// each with two combinational read ports and one synchronous write port.
module cpu_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] gp_saddr,
  input  logic [ADDR_W-1:0] gp_taddr,
  input  logic [ADDR_W-1:0] gp_daddr,
  input  logic [DATA_W-1:0] gp_wdata,
  input  logic              gp_we,
  output logic [DATA_W-1:0] gp_sdata,
  output logic [DATA_W-1:0] gp_tdata,
  input  logic [ADDR_W-1:0] fp_saddr,
  input  logic [ADDR_W-1:0] fp_taddr,
  input  logic [ADDR_W-1:0] fp_daddr,
  input  logic [DATA_W-1:0] fp_wdata,
  input  logic              fp_we,
  output logic [DATA_W-1:0] fp_sdata,
  output logic [DATA_W-1:0] fp_tdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] gp_q [DEPTH];
  logic [DATA_W-1:0] fp_q [DEPTH];

  // GP writes to r0 are dropped so r0 storage never leaves zero
  logic gp_wr_c;
  logic fp_wr_c;
  assign gp_wr_c = gp_we && (gp_daddr != '0);
  assign fp_wr_c = fp_we;

  // Forwarding is suppressed during reset so every output reads zero then
  logic gp_byp_c;
  logic fp_byp_c;
  assign gp_byp_c = BYPASS && rstn && gp_wr_c;
  assign fp_byp_c = BYPASS && rstn && fp_wr_c;

  // Register storage for both files; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        gp_q[i] <= '0;
        fp_q[i] <= '0;
      end
    end else begin
      if (gp_wr_c) gp_q[gp_daddr] <= gp_wdata;
      if (fp_wr_c) fp_q[fp_daddr] <= fp_wdata;
    end
  end

  // GP read with r0 forced to zero and optional same-cycle forwarding
  function automatic logic [DATA_W-1:0] gp_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = gp_q[a];
    if (gp_byp_c && (a == gp_daddr)) v = gp_wdata;
    if (a == '0) v = '0;
    return v;
  endfunction

  // FP read: f0 is ordinary, optional same-cycle forwarding
  function automatic logic [DATA_W-1:0] fp_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = fp_q[a];
    if (fp_byp_c && (a == fp_daddr)) v = fp_wdata;
    return v;
  endfunction

  // Combinational operand read ports
  always_comb begin
    gp_sdata = '0;
    gp_tdata = '0;
    fp_sdata = '0;
    fp_tdata = '0;
    gp_sdata = gp_read(gp_saddr);
    gp_tdata = gp_read(gp_taddr);
    fp_sdata = fp_read(fp_saddr);
    fp_tdata = fp_read(fp_taddr);
  end

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench for cpu_regfile: one instance with forwarding, one without,
// driven from the same inputs.
module tb_cpu_regfile;

  logic        clk;
  logic        rstn;
  logic [4:0]  gp_saddr, gp_taddr, gp_daddr;
  logic [31:0] gp_wdata;
  logic        gp_we;
  logic [4:0]  fp_saddr, fp_taddr, fp_daddr;
  logic [31:0] fp_wdata;
  logic        fp_we;
  logic [31:0] gp_s1, gp_t1, fp_s1, fp_t1;
  logic [31:0] gp_s0, gp_t0, fp_s0, fp_t0;

  int n_cmp = 0;
  int n_err = 0;

  cpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .gp_saddr(gp_saddr), .gp_taddr(gp_taddr), .gp_daddr(gp_daddr),
    .gp_wdata(gp_wdata), .gp_we(gp_we), .gp_sdata(gp_s1), .gp_tdata(gp_t1),
    .fp_saddr(fp_saddr), .fp_taddr(fp_taddr), .fp_daddr(fp_daddr),
    .fp_wdata(fp_wdata), .fp_we(fp_we), .fp_sdata(fp_s1), .fp_tdata(fp_t1)
  );

  cpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rstn(rstn),
    .gp_saddr(gp_saddr), .gp_taddr(gp_taddr), .gp_daddr(gp_daddr),
    .gp_wdata(gp_wdata), .gp_we(gp_we), .gp_sdata(gp_s0), .gp_tdata(gp_t0),
    .fp_saddr(fp_saddr), .fp_taddr(fp_taddr), .fp_daddr(fp_daddr),
    .fp_wdata(fp_wdata), .fp_we(fp_we), .fp_sdata(fp_s0), .fp_tdata(fp_t0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output order in every expectation: gp_s, gp_t, fp_s, fp_t
  typedef struct {
    string       name;
    logic        gwe;
    logic [4:0]  gd, gs, gt;
    logic [31:0] gw;
    logic        fwe;
    logic [4:0]  fd, fs, ft;
    logic [31:0] fw;
    logic [3:0][31:0] pre1;
    logic [3:0][31:0] pre0;
    logic [3:0][31:0] post;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_quad(input string name, input logic [3:0][31:0] e, input bit byp);
    if (byp) begin
      chk({name, ".gp_s"}, gp_s1, e[0]);
      chk({name, ".gp_t"}, gp_t1, e[1]);
      chk({name, ".fp_s"}, fp_s1, e[2]);
      chk({name, ".fp_t"}, fp_t1, e[3]);
    end else begin
      chk({name, ".nb.gp_s"}, gp_s0, e[0]);
      chk({name, ".nb.gp_t"}, gp_t0, e[1]);
      chk({name, ".nb.fp_s"}, fp_s0, e[2]);
      chk({name, ".nb.fp_t"}, fp_t0, e[3]);
    end
  endtask

  task automatic idle_inputs();
    gp_we = 1'b0; gp_daddr = '0; gp_wdata = '0; gp_saddr = '0; gp_taddr = '0;
    fp_we = 1'b0; fp_daddr = '0; fp_wdata = '0; fp_saddr = '0; fp_taddr = '0;
  endtask

  task automatic set_vec(input string n, input logic gwe, input logic [4:0] gd,
                         input logic [31:0] gw, input logic [4:0] gs, input logic [4:0] gt,
                         input logic fwe, input logic [4:0] fd, input logic [31:0] fw,
                         input logic [4:0] fs, input logic [4:0] ft,
                         input logic [3:0][31:0] pre1, input logic [3:0][31:0] pre0,
                         input logic [3:0][31:0] post, output vec_t v);
    v.name = n; v.gwe = gwe; v.gd = gd; v.gw = gw; v.gs = gs; v.gt = gt;
    v.fwe = fwe; v.fd = fd; v.fw = fw; v.fs = fs; v.ft = ft;
    v.pre1 = pre1; v.pre0 = pre0; v.post = post;
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b1;

    // Vectors applied in sequence from a freshly reset state
    set_vec("basic", 1, 1, 32'd7, 1, 2, 1, 1, 32'd15, 1, 2,
            {32'd0, 32'd15, 32'd0, 32'd7}, {32'd0, 32'd0, 32'd0, 32'd0},
            {32'd0, 32'd15, 32'd0, 32'd7}, vecs[0]);
    set_vec("zero_reg", 1, 0, 32'd7, 0, 1, 1, 0, 32'd15, 0, 1,
            {32'd15, 32'd15, 32'd7, 32'd0}, {32'd15, 32'd0, 32'd7, 32'd0},
            {32'd15, 32'd15, 32'd7, 32'd0}, vecs[1]);
    set_vec("we_off", 0, 2, 32'hDEADBEEF, 2, 0, 0, 2, 32'hDEADBEEF, 2, 0,
            {32'd15, 32'd0, 32'd0, 32'd0}, {32'd15, 32'd0, 32'd0, 32'd0},
            {32'd15, 32'd0, 32'd0, 32'd0}, vecs[2]);
    set_vec("we_on", 1, 3, 32'hDEADBEEF, 3, 3, 1, 3, 32'hDEADBEEF, 3, 3,
            {4{32'hDEADBEEF}}, {4{32'h0}}, {4{32'hDEADBEEF}}, vecs[3]);
    set_vec("bypass", 1, 4, 32'h12345678, 4, 3, 1, 4, 32'hCAFEF00D, 1, 4,
            {32'hCAFEF00D, 32'd15, 32'hDEADBEEF, 32'h12345678},
            {32'h0, 32'd15, 32'hDEADBEEF, 32'h0},
            {32'hCAFEF00D, 32'd15, 32'hDEADBEEF, 32'h12345678}, vecs[4]);
    set_vec("both_files", 1, 1, 32'hFFFFFFFF, 1, 31, 1, 31, 32'h80000000, 31, 0,
            {32'd15, 32'h80000000, 32'h0, 32'hFFFFFFFF},
            {32'd15, 32'h0, 32'h0, 32'd7},
            {32'd15, 32'h80000000, 32'h0, 32'hFFFFFFFF}, vecs[5]);
    set_vec("readback", 0, 1, 32'h0, 4, 1, 0, 0, 32'h0, 4, 3,
            {32'hDEADBEEF, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h12345678},
            {32'hDEADBEEF, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h12345678},
            {32'hDEADBEEF, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h12345678}, vecs[6]);

    // Reset: all addresses read zero, and forwarding is blocked while low
    #2 rstn = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      gp_saddr = 5'(a); gp_taddr = 5'(31 - a);
      fp_saddr = 5'(a); fp_taddr = 5'(31 - a);
      #1;
      chk_quad($sformatf("reset_a%0d", a), '0, 1'b1);
      chk_quad($sformatf("reset_a%0d", a), '0, 1'b0);
    end
    gp_we = 1'b1; gp_daddr = 5'd9; gp_wdata = 32'h55AA55AA; gp_saddr = 5'd9;
    fp_we = 1'b1; fp_daddr = 5'd9; fp_wdata = 32'h55AA55AA; fp_saddr = 5'd9;
    @(posedge clk); #1;
    chk("reset_wr_gp", gp_s1, 32'h0);
    chk("reset_wr_fp", fp_s1, 32'h0);
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    gp_saddr = 5'd9; fp_saddr = 5'd9;
    @(posedge clk); #1;
    chk("reset_wr_gp_after", gp_s1, 32'h0);
    chk("reset_wr_fp_after", fp_s0, 32'h0);

    // Table-driven vectors: check pre-edge on both instances, then post-edge
    for (int i = 0; i < 7; i++) begin
      gp_we = vecs[i].gwe; gp_daddr = vecs[i].gd; gp_wdata = vecs[i].gw;
      gp_saddr = vecs[i].gs; gp_taddr = vecs[i].gt;
      fp_we = vecs[i].fwe; fp_daddr = vecs[i].fd; fp_wdata = vecs[i].fw;
      fp_saddr = vecs[i].fs; fp_taddr = vecs[i].ft;
      #1;
      chk_quad({vecs[i].name, ".pre"}, vecs[i].pre1, 1'b1);
      chk_quad({vecs[i].name, ".pre"}, vecs[i].pre0, 1'b0);
      @(posedge clk); #1;
      chk_quad({vecs[i].name, ".post"}, vecs[i].post, 1'b1);
      chk_quad({vecs[i].name, ".post"}, vecs[i].post, 1'b0);
    end

    // Async reset mid-operation: load r5/f5, then drop rstn between edges
    idle_inputs();
    gp_we = 1'b1; gp_daddr = 5'd5; gp_wdata = 32'hA5A5A5A5;
    fp_we = 1'b1; fp_daddr = 5'd5; fp_wdata = 32'h3F800000;
    @(posedge clk); #1;
    gp_we = 1'b0; fp_we = 1'b0;
    gp_saddr = 5'd5; gp_taddr = 5'd5; fp_saddr = 5'd5; fp_taddr = 5'd5;
    #1;
    chk_quad("load5", {32'h3F800000, 32'h3F800000, 32'hA5A5A5A5, 32'hA5A5A5A5}, 1'b1);
    chk_quad("load5", {32'h3F800000, 32'h3F800000, 32'hA5A5A5A5, 32'hA5A5A5A5}, 1'b0);
    gp_we = 1'b1; gp_wdata = 32'h11111111;
    #1;
    chk("fwd_before_rst", gp_s1, 32'h11111111);
    #1 rstn = 1'b0;
    #1;
    chk_quad("async_rst", '0, 1'b1);
    chk_quad("async_rst", '0, 1'b0);
    @(posedge clk); #1;
    chk_quad("rst_held_edge", '0, 1'b1);
    gp_we = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk_quad("after_release", '0, 1'b1);
    chk_quad("after_release", '0, 1'b0);
    gp_saddr = 5'd1; fp_saddr = 5'd31;
    #1;
    chk("after_release_r1", gp_s1, 32'h0);
    chk("after_release_f31", fp_s0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
